// File: rtl/bvlshr_inv_search_ctrl_pkg.sv
// Shared definitions for the bit-vector inversion controllers: FSM states,
// default operand width and the saturating logical shift right.
package bvinv_pkg;

  localparam int unsigned BVINV_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SEARCH,
    DONE
  } state_t;

  // a >> s with zero fill over a w-bit operand; shifts of w or more give 0.
  function automatic logic [31:0] lshr_sat(input logic [31:0] a,
                                           input logic [31:0] s,
                                           input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    if (s >= 32'(w)) return '0;
    return (a & mask) >> s;
  endfunction

endpackage

// File: rtl/bvlshr_inv_search_ctrl_if.sv
// Query/result handshake bundle of the lshr inversion search controller.
interface bvlshr_inv_search_ctrl_if
  import bvinv_pkg::*;
#(
  parameter int WIDTH = BVINV_WIDTH,
  parameter int CNT_W = WIDTH + 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] s_in;
  logic [WIDTH-1:0] t_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x_out;
  logic             sat;
  logic [CNT_W-1:0] iter_count;

  modport master (
    output in_valid, s_in, t_in, out_ready,
    input  in_ready, out_valid, x_out, sat, iter_count
  );

  modport slave (
    input  in_valid, s_in, t_in, out_ready,
    output in_ready, out_valid, x_out, sat, iter_count
  );
endinterface

// File: rtl/bvlshr_inv_search_ctrl_unit.sv
// Shared combinational shift datapath: y = lshr(a, s), saturating to 0.
module bvlshr_unit
  import bvinv_pkg::*;
#(
  parameter int WIDTH = BVINV_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_s,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = WIDTH'(lshr_sat(32'(i_a), 32'(i_s), WIDTH));
endmodule

// File: rtl/bvlshr_inv_search_ctrl.sv
// Sequential solver for lshr(x, s) == t: one-cycle invertibility check,
// then linear enumeration of x through one shared shift unit.
module bvlshr_inv_search_ctrl
  import bvinv_pkg::*;
#(
  parameter int WIDTH = BVINV_WIDTH,
  parameter int CNT_W = WIDTH + 1
) (
  input logic                      clk,
  input logic                      rst,
  bvlshr_inv_search_ctrl_if.slave  bus
);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_s, r_t, r_xCnt, r_xOut;
  logic             r_sat;
  logic [CNT_W-1:0] r_iter;

  logic [WIDTH-1:0] w_chkA, w_unitA, w_y;
  logic             w_match, w_lastCand, w_accept, w_release;
  logic             w_inReady, w_outValid;

  // CHECK feeds trunc(t << s) back through the unit; SEARCH feeds the candidate.
  assign w_chkA  = r_t << r_s;
  assign w_unitA = (r_state == SEARCH) ? r_xCnt : w_chkA;

  bvlshr_unit #(.WIDTH(WIDTH)) u_shift (
    .i_a (w_unitA),
    .i_s (r_s),
    .o_y (w_y)
  );

  assign w_match    = (w_y == r_t);
  assign w_lastCand = (r_xCnt == {WIDTH{1'b1}});
  assign w_accept   = (r_state == IDLE) && bus.in_valid;
  assign w_release  = (r_state == DONE) && bus.out_ready;

  always_comb begin
    w_next     = r_state;
    w_inReady  = 1'b0;
    w_outValid = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (w_accept) w_next = CHECK;
      end
      CHECK:  w_next = w_match ? SEARCH : DONE;
      SEARCH: if (w_match || w_lastCand) w_next = DONE;
      DONE: begin
        w_outValid = 1'b1;
        if (w_release) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= '0;
      r_t    <= '0;
      r_xCnt <= '0;
      r_xOut <= '0;
      r_sat  <= 1'b0;
      r_iter <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_s    <= bus.s_in;
            r_t    <= bus.t_in;
            r_iter <= '0;
          end
        end
        CHECK: begin
          if (w_match) begin
            r_xCnt <= '0;
          end else begin
            r_sat  <= 1'b0;
            r_xOut <= '0;
          end
        end
        SEARCH: begin
          r_iter <= r_iter + CNT_W'(1);
          if (w_match) begin
            r_xOut <= r_xCnt;
            r_sat  <= 1'b1;
          end else if (w_lastCand) begin
            r_xOut <= '0;
            r_sat  <= 1'b0;
          end else begin
            r_xCnt <= r_xCnt + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = w_inReady;
  assign bus.out_valid  = w_outValid;
  assign bus.x_out      = r_xOut;
  assign bus.sat        = r_sat;
  assign bus.iter_count = r_iter;
endmodule

// File: tb/tb_bvlshr_inv_search_ctrl.sv
// Directed and exhaustive bench for the lshr inversion search controller.
module tb_bvlshr_inv_search_ctrl;
  import bvinv_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  bvlshr_inv_search_ctrl_if #(.WIDTH(4), .CNT_W(5)) bus ();

  bvlshr_inv_search_ctrl #(.WIDTH(4), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] m_lshr(input logic [3:0] a, input int s);
    return (s >= 4) ? 4'd0 : (a >> s);
  endfunction

  // The give-up branch of SEARCH must never be taken after a passing check.
  always @(negedge clk) begin
    if (!rst && dut.r_state == SEARCH && dut.w_lastCand && !dut.w_match) begin
      checks++;
      $display("[TB] FAIL search_exhausted: s=%0d t=%0d reached x=15 without match",
               dut.r_s, dut.r_t);
    end
  end

  // Called at a negedge right after the accepting edge; lat is the edge index
  // (relative to acceptance) at which out_valid is first sampled high.
  task automatic wait_result(output int lat);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      checks++;
      $display("[TB] FAIL result_timeout: out_valid=%0b after %0d cycles, required 1",
               bus.out_valid, lat);
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_query(input logic [3:0] s, input logic [3:0] t, input int stall,
                           output logic [3:0] x, output logic sat,
                           output logic [4:0] iter, output int lat);
    int n;
    bus.s_in      = s;
    bus.t_in      = t;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      $display("[TB] FAIL accept_timeout: in_ready=%0b, required 1", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    wait_result(lat);
    x    = bus.x_out;
    sat  = bus.sat;
    iter = bus.iter_count;
    repeat (stall) @(negedge clk);
    release_result();
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.s_in      = '0;
    bus.t_in      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %0b want 1", bus.in_ready); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %0b want 0", bus.out_valid); else passes++;
    checks++; if (bus.x_out !== 4'd0) $display("[TB] FAIL reset_x_out: got %0d want 0", bus.x_out); else passes++;
    checks++; if (bus.sat !== 1'b0) $display("[TB] FAIL reset_sat: got %0b want 0", bus.sat); else passes++;
    checks++; if (bus.iter_count !== 5'd0) $display("[TB] FAIL reset_iter: got %0d want 0", bus.iter_count); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_sat_basic();
    logic [3:0] x; logic sat; logic [4:0] iter; int lat;
    run_query(4'd1, 4'd3, 1, x, sat, iter, lat);
    checks++; if (sat !== 1'b1) $display("[TB] FAIL s1t3_sat: got %0b want 1", sat); else passes++;
    checks++; if (x !== 4'd6) $display("[TB] FAIL s1t3_x: got %0d want 6", x); else passes++;
    checks++; if (iter !== 5'd7) $display("[TB] FAIL s1t3_iter: got %0d want 7", iter); else passes++;
    checks++; if (lat != 9) $display("[TB] FAIL s1t3_latency: got %0d want 9", lat); else passes++;
  endtask

  task automatic test_unsat_check();
    logic [3:0] x; logic sat; logic [4:0] iter; int lat;
    run_query(4'd2, 4'd4, 0, x, sat, iter, lat);
    checks++; if (sat !== 1'b0) $display("[TB] FAIL s2t4_sat: got %0b want 0", sat); else passes++;
    checks++; if (x !== 4'd0) $display("[TB] FAIL s2t4_x: got %0d want 0", x); else passes++;
    checks++; if (iter !== 5'd0) $display("[TB] FAIL s2t4_iter: got %0d want 0", iter); else passes++;
    checks++; if (lat != 2) $display("[TB] FAIL s2t4_latency: got %0d want 2", lat); else passes++;
  endtask

  task automatic test_wide_shift();
    logic [3:0] x; logic sat; logic [4:0] iter; int lat;
    run_query(4'd5, 4'd0, 0, x, sat, iter, lat);
    checks++; if (sat !== 1'b1) $display("[TB] FAIL s5t0_sat: got %0b want 1", sat); else passes++;
    checks++; if (x !== 4'd0) $display("[TB] FAIL s5t0_x: got %0d want 0", x); else passes++;
    checks++; if (iter !== 5'd1) $display("[TB] FAIL s5t0_iter: got %0d want 1", iter); else passes++;
    run_query(4'd5, 4'd1, 0, x, sat, iter, lat);
    checks++; if (sat !== 1'b0) $display("[TB] FAIL s5t1_sat: got %0b want 0", sat); else passes++;
    checks++; if (lat != 2) $display("[TB] FAIL s5t1_latency: got %0d want 2", lat); else passes++;
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.s_in = 4'd0; bus.t_in = 4'd15; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wait_result(lat);
    checks++; if (bus.x_out !== 4'd15) $display("[TB] FAIL s0t15_x: got %0d want 15", bus.x_out); else passes++;
    checks++; if (bus.sat !== 1'b1) $display("[TB] FAIL s0t15_sat: got %0b want 1", bus.sat); else passes++;
    checks++; if (bus.iter_count !== 5'd16) $display("[TB] FAIL s0t15_iter: got %0d want 16", bus.iter_count); else passes++;
    checks++; if (lat != 18) $display("[TB] FAIL s0t15_latency: got %0d want 18", lat); else passes++;
    bus.s_in = 4'd3; bus.t_in = 4'd1; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || bus.x_out !== 4'd15 || bus.sat !== 1'b1 || bus.iter_count !== 5'd16)
        $display("[TB] FAIL stall_hold%0d: v=%0b x=%0d sat=%0b it=%0d want 1/15/1/16", i, bus.out_valid, bus.x_out, bus.sat, bus.iter_count);
      else passes++;
      checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL stall_in_ready%0d: got %0b want 0", i, bus.in_ready); else passes++;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL handshake_drop: out_valid=%0b want 0", bus.out_valid); else passes++;
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL handshake_idle: in_ready=%0b want 1", bus.in_ready); else passes++;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL second_accept: in_ready=%0b want 0", bus.in_ready); else passes++;
    wait_result(lat);
    checks++; if (bus.x_out !== 4'd8) $display("[TB] FAIL s3t1_x: got %0d want 8", bus.x_out); else passes++;
    checks++; if (bus.iter_count !== 5'd9) $display("[TB] FAIL s3t1_iter: got %0d want 9", bus.iter_count); else passes++;
    checks++; if (lat != 11) $display("[TB] FAIL s3t1_latency: got %0d want 11", lat); else passes++;
    release_result();
  endtask

  task automatic test_reset_mid_search();
    logic [3:0] x; logic sat; logic [4:0] iter; int lat; int n;
    bus.s_in = 4'd0; bus.t_in = 4'd15; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.iter_count !== 5'd6 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++; if (bus.iter_count !== 5'd6) $display("[TB] FAIL abort_reach_iter6: got %0d want 6", bus.iter_count); else passes++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) $display("[TB] FAIL abort_handshake: rdy=%0b vld=%0b want 1/0", bus.in_ready, bus.out_valid); else passes++;
    checks++; if (bus.x_out !== 4'd0 || bus.sat !== 1'b0 || bus.iter_count !== 5'd0)
      $display("[TB] FAIL abort_outputs: x=%0d sat=%0b it=%0d want 0/0/0", bus.x_out, bus.sat, bus.iter_count);
    else passes++;
    run_query(4'd1, 4'd0, 0, x, sat, iter, lat);
    checks++; if (x !== 4'd0 || sat !== 1'b1 || iter !== 5'd1) $display("[TB] FAIL after_abort: x=%0d sat=%0b it=%0d want 0/1/1", x, sat, iter); else passes++;
    checks++; if (lat != 3) $display("[TB] FAIL after_abort_latency: got %0d want 3", lat); else passes++;
  endtask

  task automatic test_exhaustive();
    logic [3:0] x; logic sat; logic [4:0] iter; int lat;
    logic expSat; logic [3:0] expX; logic [4:0] expIter; int expLat;
    for (int s = 0; s < 16; s++) begin
      for (int t = 0; t < 16; t++) begin
        expSat = 1'b0;
        expX   = 4'd0;
        for (int c = 0; c < 16; c++) begin
          if (!expSat && m_lshr(4'(c), s) == 4'(t)) begin
            expSat = 1'b1;
            expX   = 4'(c);
          end
        end
        expIter = expSat ? 5'(expX) + 5'd1 : 5'd0;
        expLat  = expSat ? 3 + int'(expX) : 2;
        run_query(4'(s), 4'(t), int'($urandom_range(0, 2)), x, sat, iter, lat);
        checks++; if (sat !== expSat) $display("[TB] FAIL ex_sat s=%0d t=%0d: got %0b want %0b", s, t, sat, expSat); else passes++;
        checks++; if (x !== expX) $display("[TB] FAIL ex_min_x s=%0d t=%0d: got %0d want %0d", s, t, x, expX); else passes++;
        checks++; if (iter !== expIter) $display("[TB] FAIL ex_iter s=%0d t=%0d: got %0d want %0d", s, t, iter, expIter); else passes++;
        checks++; if (lat != expLat) $display("[TB] FAIL ex_latency s=%0d t=%0d: got %0d want %0d", s, t, lat, expLat); else passes++;
        if (sat === 1'b1) begin
          checks++; if (m_lshr(x, s) !== 4'(t)) $display("[TB] FAIL ex_solution s=%0d t=%0d: lshr(%0d)=%0d want %0d", s, t, x, m_lshr(x, s), t); else passes++;
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    $display("[TB] starting bvlshr_inv_search_ctrl bench");
    test_reset();
    test_sat_basic();
    test_unsat_check();
    test_wide_shift();
    test_back_to_back();
    test_reset_mid_search();
    test_exhaustive();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
